led_frame_serializer: RTL and testbench



---
 rtl/led_frame_serializer_if.sv | 21 ++
 rtl/led_frame_serializer.sv | 231 +++++++++++++++++++++++
 tb/tb_led_frame_serializer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/led_frame_serializer_if.sv
// FIFO read-port bundle between the zone-brightness prefetch FIFO and its reader.
// The reader (master) issues pops; the FIFO (slave) presents the head word and its valid flag.
interface led_frame_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_vld;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_rd_vld,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_rd_vld,
        output fifo_rd_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/led_frame_serializer.sv
// Pops ZONE_NUM words per frame from the prefetch FIFO and shifts them MSB-first onto sclk/sdo, then latches.
// Define LED_UNDERRUN_FILL_EN to substitute FILL_VALUE for timed-out zones instead of aborting the frame.
module led_frame_serializer #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  ZONE_NUM   = 64,
    parameter int                  SCLK_DIV   = 4,
    parameter int                  TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   frame_start,
    led_frame_serializer_if.master fifo,
    output logic                   led_sclk,
    output logic                   led_sdo,
    output logic                   led_latch,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   underrun
);

    localparam int ZW = (ZONE_NUM > 1) ? $clog2(ZONE_NUM) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONE_NUM - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    logic [1:0]            state_reg,    state_next;
    logic [ZW-1:0]         zone_cnt_reg, zone_cnt_next;
    logic [BW-1:0]         bit_cnt_reg,  bit_cnt_next;
    logic [DW-1:0]         div_cnt_reg,  div_cnt_next;
    logic [WW-1:0]         wait_cnt_reg, wait_cnt_next;
    logic                  high_reg,     high_next;
    logic [DATA_WIDTH-1:0] shreg_reg,    shreg_next;
    logic                  sclk_reg,     sclk_next;
    logic                  sdo_reg,      sdo_next;
    logic                  latch_reg,    latch_next;
    logic                  busy_reg,     busy_next;
    logic                  done_reg,     done_next;
    logic                  underrun_reg, underrun_next;
`ifdef LED_UNDERRUN_FILL_EN
    logic                  seen_reg,     seen_next;
`endif

    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  pop;

    // Pop is combinational so the head word is consumed in the same cycle it is captured.
    assign pop             = (state_reg == FETCH) && fifo.fifo_rd_vld;
    assign fifo.fifo_rd_en = pop;

    always_comb begin
        state_next    = state_reg;
        zone_cnt_next = zone_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        div_cnt_next  = div_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        high_next     = high_reg;
        shreg_next    = shreg_reg;
        sclk_next     = sclk_reg;
        sdo_next      = sdo_reg;
        latch_next    = latch_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        underrun_next = 1'b0;
`ifdef LED_UNDERRUN_FILL_EN
        seen_next     = seen_reg;
`endif
        load_en       = 1'b0;
        load_data     = fifo.fifo_rd_data;
        shifted       = shreg_reg << 1;

        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    state_next    = FETCH;
                    zone_cnt_next = '0;
                    wait_cnt_next = '0;
                    busy_next     = 1'b1;
`ifdef LED_UNDERRUN_FILL_EN
                    seen_next     = 1'b0;
`endif
                end
            end

            FETCH: begin
                if (pop) begin
                    load_en   = 1'b1;
                    load_data = fifo.fifo_rd_data;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    shreg_next    = FILL_VALUE;
                    wait_cnt_next = '0;
`ifdef LED_UNDERRUN_FILL_EN
                    // Only the first starved zone of a frame is reported.
                    underrun_next = !seen_reg;
                    seen_next     = 1'b1;
                    load_en       = 1'b1;
                    load_data     = FILL_VALUE;
`else
                    underrun_next = 1'b1;
                    busy_next     = 1'b0;
                    sclk_next     = 1'b0;
                    sdo_next      = 1'b0;
                    state_next    = IDLE;
`endif
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end

                if (load_en) begin
                    shreg_next    = load_data;
                    sdo_next      = load_data[DATA_WIDTH-1];
                    sclk_next     = 1'b0;
                    bit_cnt_next  = '0;
                    div_cnt_next  = '0;
                    high_next     = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = SHIFT;
                end
            end

            SHIFT: begin
                if (div_cnt_reg != DIV_LAST) begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end else begin
                    div_cnt_next = '0;
                    if (!high_reg) begin
                        high_next = 1'b1;
                        sclk_next = 1'b1;
                    end else if (bit_cnt_reg == BIT_LAST) begin
                        high_next     = 1'b0;
                        sclk_next     = 1'b0;
                        sdo_next      = 1'b0;
                        zone_cnt_next = zone_cnt_reg + 1'b1;
                        wait_cnt_next = '0;
                        if (zone_cnt_reg == ZONE_LAST) begin
                            state_next = LATCH;
                            latch_next = 1'b1;
                        end else begin
                            state_next = FETCH;
                        end
                    end else begin
                        // Data changes only at the start of a low phase.
                        high_next    = 1'b0;
                        sclk_next    = 1'b0;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shreg_next   = shifted;
                        sdo_next     = shifted[DATA_WIDTH-1];
                    end
                end
            end

            LATCH: begin
                if (div_cnt_reg != DIV_LAST) begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end else begin
                    div_cnt_next = '0;
                    latch_next   = 1'b0;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                sclk_next  = 1'b0;
                sdo_next   = 1'b0;
                latch_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_reg    <= IDLE;
            zone_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            div_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            high_reg     <= 1'b0;
            shreg_reg    <= '0;
            sclk_reg     <= 1'b0;
            sdo_reg      <= 1'b0;
            latch_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
`ifdef LED_UNDERRUN_FILL_EN
            seen_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            zone_cnt_reg <= zone_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            div_cnt_reg  <= div_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            high_reg     <= high_next;
            shreg_reg    <= shreg_next;
            sclk_reg     <= sclk_next;
            sdo_reg      <= sdo_next;
            latch_reg    <= latch_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            underrun_reg <= underrun_next;
`ifdef LED_UNDERRUN_FILL_EN
            seen_reg     <= seen_next;
`endif
        end
    end

    assign led_sclk   = sclk_reg;
    assign led_sdo    = sdo_reg;
    assign led_latch  = latch_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_led_frame_serializer.sv
// Directed bench for led_frame_serializer: table of frame scenarios plus hand-written reset sequences.
// Cycle 0 is the frame_start cycle; frame_done is expected at cycle 1 + 4*33 + 2 = 135 for a clean frame.
module tb_led_frame_serializer;

    localparam int DWID = 8;
    localparam int ZN   = 4;
    localparam int SDIV = 2;
    localparam int TO   = 16;
    localparam int RUN  = 200;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    logic frame_start = 1'b0;
    logic led_sclk, led_sdo, led_latch, busy, frame_done, underrun;

    led_frame_serializer_if #(.DATA_WIDTH(DWID)) fifo ();

    led_frame_serializer #(
        .DATA_WIDTH(DWID), .ZONE_NUM(ZN), .SCLK_DIV(SDIV), .TIMEOUT(TO), .FILL_VALUE(8'h00)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start), .fifo(fifo.master),
        .led_sclk(led_sclk), .led_sdo(led_sdo), .led_latch(led_latch),
        .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [31:0] words;
        int          nwords;
        int          stall_at;
        int          stall_len;
        int          refire_at;
        int          exp_pops;
        int          exp_done;
        int          exp_ur;
        logic [31:0] exp_bits;
        int          exp_nbits;
        int          exp_latch;
    } vec_t;

    vec_t vecs[5];

    logic [7:0]  q[$];
    int          cyc, stall_at, stall_len;
    int          pops, first_pop, nbits, latch_n, done_n, done_cyc, ur_n, ur_cyc, hold_bad;
    logic        busy1;
    logic        prev_sclk;
    logic [31:0] got;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; pops = 0; first_pop = -1; nbits = 0; got = '0;
        latch_n = 0; done_n = 0; done_cyc = -1; ur_n = 0; ur_cyc = -1;
        hold_bad = 0; busy1 = 1'b0; prev_sclk = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample just after.
    task automatic cycle(input logic fs);
        logic stalled;
        @(negedge rd_clk);
        stalled = (cyc >= stall_at) && (cyc < stall_at + stall_len);
        frame_start = fs;
        if (q.size() > 0 && !stalled) begin
            fifo.fifo_rd_vld  = 1'b1;
            fifo.fifo_rd_data = q[0];
        end else begin
            fifo.fifo_rd_vld  = 1'b0;
            fifo.fifo_rd_data = '0;
        end
        #1;
        if (fifo.fifo_rd_en) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            void'(q.pop_front());
        end
        if (led_sclk && !prev_sclk) begin
            got = {got[30:0], led_sdo};
            nbits++;
        end
        prev_sclk = led_sclk;
        if (stalled && (led_sclk || led_sdo)) hold_bad++;
        if (led_latch) latch_n++;
        if (frame_done) begin done_n++; done_cyc = cyc; end
        if (underrun) begin ur_n++; ur_cyc = cyc; end
        if (cyc == 1) busy1 = busy;
        cyc++;
    endtask

    initial begin
        vecs[0] = '{32'hA53CFF00, 4, -1, 0, -1, 4, 135, -1, 32'hA53CFF00, 32, 2};
        vecs[1] = '{32'hA53CFF00, 4, 67, 10, -1, 4, 145, -1, 32'hA53CFF00, 32, 2};
        vecs[2] = '{32'h01807E81, 4, -1, 0, 20, 4, 135, -1, 32'h01807E81, 32, 2};
`ifdef LED_UNDERRUN_FILL_EN
        vecs[3] = '{32'h5AC30000, 2, -1, 0, -1, 2, 165, 83, 32'h5AC30000, 32, 2};
`else
        vecs[3] = '{32'h5AC30000, 2, -1, 0, -1, 2, -1, 83, 32'h00005AC3, 16, 0};
`endif
        vecs[4] = '{32'h8001C33C, 4, -1, 0, 90, 4, 135, -1, 32'h8001C33C, 32, 2};

        fifo.fifo_rd_vld = 1'b0;
        fifo.fifo_rd_data = '0;
        stall_at = -1; stall_len = 0;
        repeat (3) @(negedge rd_clk);
        #1;
        check("reset_outputs", int'({fifo.fifo_rd_en, led_sclk, led_sdo, led_latch, busy, frame_done, underrun}), 0);
        @(negedge rd_clk);
        rd_rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            q.delete();
            for (int i = 0; i < vecs[v].nwords; i++) q.push_back(vecs[v].words[31 - 8*i -: 8]);
            stall_at  = vecs[v].stall_at;
            stall_len = vecs[v].stall_len;
            for (int c = 0; c < RUN; c++) cycle(c == 0 || c == vecs[v].refire_at);
            $display("vec %0d: pops=%0d bits=%0d stream=%0h latch=%0d done@%0d underrun@%0d",
                     v, pops, nbits, got, latch_n, done_cyc, ur_cyc);
            check($sformatf("v%0d_pops", v), pops, vecs[v].exp_pops);
            check($sformatf("v%0d_first_pop", v), first_pop, 1);
            check($sformatf("v%0d_busy_c1", v), int'(busy1), 1);
            check($sformatf("v%0d_nbits", v), nbits, vecs[v].exp_nbits);
            check($sformatf("v%0d_stream", v), int'(got), int'(vecs[v].exp_bits));
            check($sformatf("v%0d_latch_cycles", v), latch_n, vecs[v].exp_latch);
            check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_done);
            check($sformatf("v%0d_done_count", v), done_n, (vecs[v].exp_done >= 0) ? 1 : 0);
            check($sformatf("v%0d_underrun_cycle", v), ur_cyc, vecs[v].exp_ur);
            check($sformatf("v%0d_underrun_count", v), ur_n, (vecs[v].exp_ur >= 0) ? 1 : 0);
            check($sformatf("v%0d_hold_low", v), hold_bad, 0);
            check($sformatf("v%0d_busy_end", v), int'(busy), 0);
        end

        // Reset in the middle of word 1, bit 2 (sdo=1 for A5).
        clear_mon();
        q.delete();
        stall_at = -1; stall_len = 0;
        q.push_back(8'hA5); q.push_back(8'h3C); q.push_back(8'hFF); q.push_back(8'h00);
        cycle(1'b1);
        for (int c = 1; c <= 10; c++) cycle(1'b0);
        check("pre_reset_sdo", int'(led_sdo), 1);
        check("pre_reset_busy", int'(busy), 1);
        rd_rst = 1'b1;
        #1;
        $display("mid-frame reset: outputs=%07b", {fifo.fifo_rd_en, led_sclk, led_sdo, led_latch, busy, frame_done, underrun});
        check("midreset_outputs", int'({fifo.fifo_rd_en, led_sclk, led_sdo, led_latch, busy, frame_done, underrun}), 0);
        check("midreset_pops", pops, 1);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        clear_mon();
        for (int c = 0; c < 40; c++) cycle(1'b0);
        $display("post-reset idle: pops=%0d latch=%0d done=%0d", pops, latch_n, done_n);
        check("post_reset_no_pop", pops, 0);
        check("post_reset_no_latch", latch_n + done_n, 0);
        check("post_reset_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
